// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO family.
package fifo_pkg;

    function automatic bit is_pow2(input int unsigned value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds,
// sticky overflow/underflow, synchronous flush and selectable FWFT/registered read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2,
    parameter bit FWFT   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W + 1)'(AE_LVL);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
        $error("fifo_param: AF_LVL must be in 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_param: AE_LVL must be in 0..DEPTH-1");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              flush;
    logic              push_ok;
    logic              pop_ok;
    logic [WIDTH-1:0]  rd_word;

    assign flush        = rst | clear;
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                          (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A push into a full FIFO is still taken when a pop frees the slot the same cycle.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok & ~flush),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : rd_word;
    end else begin : g_reg_read
        logic [WIDTH-1:0] data_q;

        // Registered read: the word leaving on pop is held until the next accepted pop.
        always_ff @(posedge clk) begin
            if (flush) begin
                data_q <= '0;
            end else if (pop_ok) begin
                data_q <= rd_word;
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: registered-read and FWFT instances share one stimulus stream.
module tb_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] r_data_out, f_data_out;
    logic       r_full, f_full, r_empty, f_empty;
    logic       r_af, f_af, r_ae, f_ae;
    logic [3:0] r_count, f_count;
    logic       r_ovf, f_ovf, r_unf, f_unf;

    int total = 0;
    int bad   = 0;

    // Scoreboard: words accepted by the FIFO, oldest first.
    logic [7:0] sb_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] exp_d0 = 8'h00;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        int         cnt;
        logic       full;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b0)) u_fifo_reg (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (r_data_out),
        .full         (r_full),
        .empty        (r_empty),
        .almost_full  (r_af),
        .almost_empty (r_ae),
        .count        (r_count),
        .overflow     (r_ovf),
        .underflow    (r_unf)
    );

    fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b1)) u_fifo_fwft (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (f_data_out),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the scoreboard state after the clock edge.
    task automatic checkOutput();
        int         n;
        logic [7:0] head;
        n    = sb_q.size();
        head = (n > 0) ? sb_q[0] : 8'h00;
        cmp("reg count", 32'(r_count), 32'(n));
        cmp("fwft count", 32'(f_count), 32'(n));
        cmp("reg full", 32'(r_full), 32'(n == DEPTH));
        cmp("fwft full", 32'(f_full), 32'(n == DEPTH));
        cmp("reg empty", 32'(r_empty), 32'(n == 0));
        cmp("fwft empty", 32'(f_empty), 32'(n == 0));
        cmp("reg almost_full", 32'(r_af), 32'(n >= AF));
        cmp("fwft almost_full", 32'(f_af), 32'(n >= AF));
        cmp("reg almost_empty", 32'(r_ae), 32'(n <= AE));
        cmp("fwft almost_empty", 32'(f_ae), 32'(n <= AE));
        cmp("reg overflow", 32'(r_ovf), 32'(m_ovf));
        cmp("fwft overflow", 32'(f_ovf), 32'(m_ovf));
        cmp("reg underflow", 32'(r_unf), 32'(m_unf));
        cmp("fwft underflow", 32'(f_unf), 32'(m_unf));
        cmp("reg data_out", 32'(r_data_out), 32'(exp_d0));
        cmp("fwft data_out", 32'(f_data_out), 32'(head));
    endtask

    // Drive one cycle of inputs, advance the scoreboard, then check after the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic p,
                                 input logic q, input logic [7:0] d);
        logic m_full, m_empty, push_ok, pop_ok;
        @(negedge clk);
        rst     = r;
        clear   = c;
        push    = p;
        pop     = q;
        data_in = d;
        if (r || c) begin
            sb_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            exp_d0 = 8'h00;
        end else begin
            m_full  = (sb_q.size() == DEPTH);
            m_empty = (sb_q.size() == 0);
            push_ok = p && (!m_full || q);
            pop_ok  = q && !m_empty;
            if (p && !push_ok) m_ovf = 1'b1;
            if (q && !pop_ok)  m_unf = 1'b1;
            if (pop_ok)  exp_d0 = sb_q.pop_front();
            if (push_ok) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        // Fill then drain: explicit expected count/flags per step.
        for (int i = 1; i <= 8; i++) begin
            tbl.push_back('{1'b1, 1'b0, 8'(i), i, i == 8, i >= 6, i <= 2, 1'b0, 1'b0});
        end
        tbl.push_back('{1'b1, 1'b0, 8'hFF, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int i = 7; i >= 0; i--) begin
            tbl.push_back('{1'b0, 1'b1, 8'h00, i, 1'b0, i >= 6, i <= 2, 1'b1, 1'b0});
        end
        tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});

        $display("[TB] reset");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cmp("reset reg data_out", 32'(r_data_out), 32'h0);
        cmp("reset count", 32'(r_count), 32'h0);

        $display("[TB] table fill/drain");
        foreach (tbl[k]) begin
            applyStimulus(1'b0, 1'b0, tbl[k].push, tbl[k].pop, tbl[k].din);
            cmp("tbl reg count", 32'(r_count), 32'(tbl[k].cnt));
            cmp("tbl fwft count", 32'(f_count), 32'(tbl[k].cnt));
            cmp("tbl full", 32'(r_full), 32'(tbl[k].full));
            cmp("tbl almost_full", 32'(r_af), 32'(tbl[k].af));
            cmp("tbl almost_empty", 32'(f_ae), 32'(tbl[k].ae));
            cmp("tbl overflow", 32'(r_ovf), 32'(tbl[k].ovf));
            cmp("tbl underflow", 32'(f_unf), 32'(tbl[k].unf));
        end
        cmp("drain last word held", 32'(r_data_out), 32'h08);

        $display("[TB] pointer wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
        cmp("wrap fwft head", 32'(f_data_out), 32'hA0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            cmp("wrap reg word", 32'(r_data_out), 32'(8'hA0 + i));
        end

        $display("[TB] simultaneous push/pop at full and empty");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        cmp("full swap head out", 32'(r_data_out), 32'h30);
        cmp("full swap count", 32'(r_count), 32'd8);
        cmp("full swap no overflow", 32'(r_ovf), 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cmp("swap tail word", 32'(r_data_out), 32'h55);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
        cmp("empty swap count", 32'(f_count), 32'd1);
        cmp("empty swap underflow", 32'(r_unf), 32'h1);
        cmp("empty swap fwft word", 32'(f_data_out), 32'h66);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cmp("empty swap later pop", 32'(r_data_out), 32'h66);

        $display("[TB] clear and reset mid-burst");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cmp("pre-clear count", 32'(r_count), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE);
        cmp("clear count", 32'(r_count), 32'd0);
        cmp("clear empty", 32'(f_empty), 32'h1);
        cmp("clear overflow", 32'(f_ovf), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hDD);
        cmp("rst count", 32'(f_count), 32'd0);
        cmp("rst reg data_out", 32'(r_data_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h42);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cmp("post-rst word", 32'(r_data_out), 32'h42);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
